dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Two-requester arbiter in front of the single-port 1024-word data memory.
- Requester 0 is the CPU MEM stage. Requester 1 is a secondary master (loader/debug bridge).
- Grants one access per cycle and drives the memory's write-enable, address, data and pc inputs.
- Returns a registered read word with a valid pulse one cycle after grant; an out-of-range access returns an error flag instead of touching memory.

Parameters:
- MAX_WAIT, 4: consecutive cycles requester 1 may lose before it is forced to win; legal 1..15.
- ADDR_LIMIT, 32'h0000_1000: first illegal byte address (4 KB window).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request, held until granted
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  32  byte address; word index is addr[11:2]
- wdata0 / wdata1  in  32  write data
- pc0 / pc1  in  32  pc tag forwarded to memory for trace
- gnt0 / gnt1  out  1  combinational grant; a transfer occurs in a cycle with req&&gnt
- rvalid0 / rvalid1  out  1  one-cycle pulse, the cycle after a granted access
- rdata0 / rdata1  out  32  read word (0 for writes or errors), held until the next rvalid
- err0 / err1  out  1  qualified by rvalid; access was out of range
- mem_we  out  1  to memory write enable
- mem_addr  out  32  to memory address
- mem_din  out  32  to memory write data
- mem_pc  out  32  to memory pc tag
- mem_dout  in  32  from memory, combinational read

Behaviour:
- Reset values:
  - rvalid*, rdata*, err*, starve_cnt all 0.
  - mem_we = 0 and gnt* = 0 while reset is high, regardless of req.
- Arbitration, combinational each cycle:
  - If req1 && starve_cnt == MAX_WAIT → gnt1.
  - Else if req0 → gnt0.
  - Else if req1 → gnt1.
  - At most one gnt is high; gnt is never high without its req.
- Starvation counter:
  - Increments when req1 && !gnt1, saturating at MAX_WAIT.
  - Cleared when gnt1 or !req1.
  - Counter width is $clog2(MAX_WAIT+1).
- Memory drive: mem_addr / mem_din / mem_pc come from the winner; when there is no grant they are driven to 0. mem_we = winner.we && in_range.
- in_range = addr < ADDR_LIMIT (unsigned). An out-of-range write is suppressed.
- Response, on the clk edge after a granted cycle:
  - rvalid of the winner = 1.
  - rdata = mem_dout if read && in_range, else 0.
  - err = !in_range.
  - The loser's rvalid is 0.
- Latency: a read is returned exactly 1 cycle after grant. A granted write is committed at the same edge the response is registered.
- Back-to-back grants to the same requester are allowed every cycle; each gets its own rvalid pulse.
- Simultaneous requests: requester 0 wins until the starvation rule forces requester 1. Requester 1 then waits at most MAX_WAIT cycles.
- Reset mid-operation:
  - A grant in the reset cycle is suppressed: no write, no rvalid the next cycle.
  - A response already pending from the cycle before reset is dropped (rvalid = 0 after reset).
- A requester dropping req before grant is legal; no response is issued and starve_cnt clears if it was requester 1.

Optional Feature:
- Macro: DM_ARB_TRACE_EN.
- When defined:
  - Each committed write prints "%d@%h: *%h <= %h" with $time, pc, addr, wdata, prefixed by the requester number.
  - Each suppressed out-of-range access prints a warning with pc and addr.
- When undefined: no $display statements; logic is identical.

Decomposition:
- Shared package dm_pkg:
  - DM_WORDS = 1024.
  - Word-index slice bounds 11:2.
  - ADDR_LIMIT default.
  - Requester id localparams REQ_CPU = 0, REQ_AUX = 1.
- One sub-module, dm_arb_starve: starvation counter plus force flag, parameterised by MAX_WAIT.
- All other logic lives in dm_arbiter.

Test Plan:
- Solo CPU write:
  - Stimulus: req0 = 1, we0 = 1, addr0 = 32'h10, wdata0 = 32'hDEADBEEF.
  - Response: gnt0 = 1, mem_we = 1, mem_addr = 32'h10.
  - Next cycle: rvalid0 = 1, err0 = 0, rdata0 = 0.
  - A following read of 32'h10 returns rdata0 = 32'hDEADBEEF one cycle after grant.
- Contention and starvation (MAX_WAIT = 4):
  - Stimulus: req0 and req1 held high continuously.
  - Response: gnt0 for cycles 0–3, gnt1 on cycle 4, then gnt0 again.
  - starve_cnt returns to 0 after gnt1.
- Out of range:
  - Stimulus: req1 = 1, we1 = 1, addr1 = 32'h1000.
  - Response: gnt1 = 1, mem_we = 0; next cycle rvalid1 = 1, err1 = 1, rdata1 = 0. Memory word 0 unchanged.
- Reset mid-access:
  - Stimulus: read granted at cycle N, reset asserted at N+1.
  - Response: rvalid0 = 0 at N+2.
  - Stimulus: write requested during reset.
  - Response: mem_we = 0, no memory change.
- Request withdrawal:
  - Stimulus: req1 high 2 cycles while losing, then low.
  - Response: starve_cnt goes 1, 2, then 0; no rvalid1.
- Trace build:
  - Stimulus: with DM_ARB_TRACE_EN defined, one write.
  - Response: exactly one line printed.
  - Without the macro: no output, same waveforms.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory arbiter: memory geometry, requester ids
// and the request/response record types used inside dm_arbiter.
package dm_pkg;

  localparam int DM_WORDS = 1024;
  localparam int WIDX_HI  = 11;
  localparam int WIDX_LO  = 2;

  // First byte address past the memory window.
  localparam logic [31:0] ADDR_LIMIT_DEF = 32'(DM_WORDS * 4);

  localparam int REQ_CPU = 0;
  localparam int REQ_AUX = 1;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } dm_req_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        err;
  } dm_rsp_t;

  function automatic logic [WIDX_HI-WIDX_LO:0] word_idx(input logic [31:0] addr);
    return addr[WIDX_HI:WIDX_LO];
  endfunction

endpackage

// File: rtl/dm_arb_starve.sv
// Starvation guard for the secondary requester: counts consecutive lost cycles and
// raises force_gnt once the count reaches MAX_WAIT (legal 1..15).
module dm_arb_starve #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic gnt,
  output logic force_gnt
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

  logic [CW-1:0] starve_cnt;

  // Saturates so a held request stays forced until it actually wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (gnt || !req) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  assign force_gnt = req && (starve_cnt == CNT_MAX);

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester arbiter in front of the single-port data memory; one access per
// cycle, registered response one cycle later. Optional write trace: DM_ARB_TRACE_EN.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int          MAX_WAIT   = 4,
  parameter logic [31:0] ADDR_LIMIT = ADDR_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [31:0] pc0,
  input  logic [31:0] pc1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_dout
);

  dm_req_t     rq [2];
  dm_req_t     win;
  dm_rsp_t     rsp0;
  dm_rsp_t     rsp1;
  logic        force_aux;
  logic        granted;
  logic        in_range;
  logic [31:0] rd_word;

  always_comb begin
    rq[REQ_CPU] = '{we: we0, addr: addr0, wdata: wdata0, pc: pc0};
    rq[REQ_AUX] = '{we: we1, addr: addr1, wdata: wdata1, pc: pc1};
  end

  dm_arb_starve #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .req       (req1),
    .gnt       (gnt1),
    .force_gnt (force_aux)
  );

  // Grants are gated by reset so nothing is committed in a reset cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (force_aux) begin
        gnt1 = 1'b1;
      end else if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  always_comb begin
    granted = gnt0 || gnt1;
    if (gnt1) begin
      win = rq[REQ_AUX];
    end else if (gnt0) begin
      win = rq[REQ_CPU];
    end else begin
      win = '0;
    end
  end

  assign in_range = (win.addr < ADDR_LIMIT);
  assign mem_we   = granted && win.we && in_range;
  assign mem_addr = win.addr;
  assign mem_din  = win.wdata;
  assign mem_pc   = win.pc;
  assign rd_word  = (!win.we && in_range) ? mem_dout : 32'h0;

  // rdata/err hold their last value until the owner is granted again.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp0 <= '0;
      rsp1 <= '0;
    end else begin
      rsp0.valid <= gnt0;
      rsp1.valid <= gnt1;
      if (gnt0) begin
        rsp0.rdata <= rd_word;
        rsp0.err   <= !in_range;
      end
      if (gnt1) begin
        rsp1.rdata <= rd_word;
        rsp1.err   <= !in_range;
      end
    end
  end

  assign rvalid0 = rsp0.valid;
  assign rdata0  = rsp0.rdata;
  assign err0    = rsp0.err;
  assign rvalid1 = rsp1.valid;
  assign rdata1  = rsp1.rdata;
  assign err1    = rsp1.err;

`ifdef DM_ARB_TRACE_EN
  always_ff @(posedge clk) begin
    if (granted) begin
      if (mem_we) begin
        $display("%0d: %d@%h: *%h <= %h", gnt1 ? REQ_AUX : REQ_CPU, $time, win.pc,
                 win.addr, win.wdata);
      end else if (!in_range) begin
        $display("dm_arbiter warning: requester %0d access suppressed pc=%h addr=%h word=%0d",
                 gnt1 ? REQ_AUX : REQ_CPU, win.pc, win.addr, word_idx(win.addr));
      end
    end
  end
`else
  // Trace build disabled: the arbiter produces no simulation output.
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: per-cycle vector table for grants and memory
// drive, plus a response scoreboard fed from an independent shadow of memory.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1, pc0, pc1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_we;
  logic [31:0] mem_addr, mem_din, mem_pc, mem_dout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic        tb_clear;
  logic [31:0] ram    [1024];
  logic [31:0] shadow [1024];

  typedef struct {
    bit          r0, w0;
    logic [31:0] a0, d0;
    bit          r1, w1;
    logic [31:0] a1, d1;
    bit          eg0, eg1, ewe;
    int          ecnt;
  } vec_t;

  typedef struct {
    int          due;
    bit          who;
    logic [31:0] rdata;
    bit          err;
  } rsp_exp_t;

  rsp_exp_t sbq [$];
  vec_t     tbl [20];

  dm_arbiter #(.MAX_WAIT(4), .ADDR_LIMIT(32'h0000_1000)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .pc0(pc0), .pc1(pc1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_pc(mem_pc),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: combinational read, write at the clock edge.
  assign mem_dout = ram[mem_addr[11:2]];
  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
    end else if (mem_we) begin
      ram[mem_addr[11:2]] <= mem_din;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: every expected response must appear exactly on its due cycle.
  always @(negedge clk) begin
    rsp_exp_t e;
    if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      check("rsp rvalid0", 32'(rvalid0), 32'(e.who == 1'b0));
      check("rsp rvalid1", 32'(rvalid1), 32'(e.who == 1'b1));
      if (e.who) begin
        check("rsp rdata1", rdata1, e.rdata);
        check("rsp err1", 32'(err1), 32'(e.err));
      end else begin
        check("rsp rdata0", rdata0, e.rdata);
        check("rsp err0", 32'(err0), 32'(e.err));
      end
    end else begin
      check("no spurious rvalid", {30'h0, rvalid1, rvalid0}, 32'h0);
    end
  end

  function automatic vec_t mk(bit r0, bit w0, logic [31:0] a0, logic [31:0] d0,
                              bit r1, bit w1, logic [31:0] a1, logic [31:0] d1,
                              bit eg0, bit eg1, bit ewe, int ecnt);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.eg0 = eg0; v.eg1 = eg1; v.ewe = ewe; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    logic [31:0] ea, ed, ep, rd;
    bit          ew, inr;
    rsp_exp_t    e;
    @(negedge clk);
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0; pc0 = 32'h0000_4000 ^ v.a0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1; pc1 = 32'h0000_8000 ^ v.a1;
    #1;
    check({tag, " gnt0"}, 32'(gnt0), 32'(v.eg0));
    check({tag, " gnt1"}, 32'(gnt1), 32'(v.eg1));
    check({tag, " mem_we"}, 32'(mem_we), 32'(v.ewe));
    check({tag, " starve_cnt"}, 32'(dut.u_starve.starve_cnt), 32'(v.ecnt));
    if (v.eg1) begin
      ea = v.a1; ed = v.d1; ep = 32'h0000_8000 ^ v.a1; ew = v.w1;
    end else if (v.eg0) begin
      ea = v.a0; ed = v.d0; ep = 32'h0000_4000 ^ v.a0; ew = v.w0;
    end else begin
      ea = 32'h0; ed = 32'h0; ep = 32'h0; ew = 1'b0;
    end
    check({tag, " mem_addr"}, mem_addr, ea);
    check({tag, " mem_din"}, mem_din, ed);
    check({tag, " mem_pc"}, mem_pc, ep);
    if (v.eg0 || v.eg1) begin
      inr     = (ea < 32'h0000_1000);
      rd      = (!ew && inr) ? shadow[ea[11:2]] : 32'h0;
      e.due   = cyc + 1;
      e.who   = v.eg1;
      e.rdata = rd;
      e.err   = !inr;
      sbq.push_back(e);
      if (ew && inr) shadow[ea[11:2]] = ed;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) shadow[i] = 32'h0;

    //          r0 w0 a0            d0            r1 w1 a1        d1            g0 g1 we cnt
    tbl[0]  = mk(1, 1, 32'h10,       32'hDEADBEEF, 0, 0, 32'h0,    32'h0,        1, 0, 1, 0);
    tbl[1]  = mk(1, 0, 32'h10,       32'h0,        0, 0, 32'h0,    32'h0,        1, 0, 0, 0);
    tbl[2]  = mk(0, 0, 32'h0,        32'h0,        0, 0, 32'h0,    32'h0,        0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 32'h0,        32'h0,        1, 1, 32'h1000, 32'h0BAD0BAD, 0, 1, 0, 0);
    tbl[4]  = mk(0, 0, 32'h0,        32'h0,        1, 0, 32'h0,    32'h0,        0, 1, 0, 0);
    tbl[5]  = mk(0, 0, 32'h0,        32'h0,        1, 1, 32'h20,   32'h12345678, 0, 1, 1, 0);
    tbl[6]  = mk(1, 0, 32'h10,       32'h0,        1, 0, 32'h20,   32'h0,        1, 0, 0, 0);
    tbl[7]  = mk(1, 0, 32'h10,       32'h0,        1, 0, 32'h20,   32'h0,        1, 0, 0, 1);
    tbl[8]  = mk(1, 0, 32'h10,       32'h0,        1, 0, 32'h20,   32'h0,        1, 0, 0, 2);
    tbl[9]  = mk(1, 0, 32'h10,       32'h0,        1, 0, 32'h20,   32'h0,        1, 0, 0, 3);
    tbl[10] = mk(1, 0, 32'h10,       32'h0,        1, 0, 32'h20,   32'h0,        0, 1, 0, 4);
    tbl[11] = mk(1, 0, 32'h10,       32'h0,        1, 0, 32'h20,   32'h0,        1, 0, 0, 0);
    tbl[12] = mk(1, 1, 32'h24,       32'hA5A5A5A5, 0, 0, 32'h0,    32'h0,        1, 0, 1, 1);
    tbl[13] = mk(1, 0, 32'h24,       32'h0,        1, 0, 32'h20,   32'h0,        1, 0, 0, 0);
    tbl[14] = mk(1, 0, 32'h10,       32'h0,        1, 0, 32'h20,   32'h0,        1, 0, 0, 1);
    tbl[15] = mk(1, 0, 32'hFFFFFFFC, 32'h0,        0, 0, 32'h0,    32'h0,        1, 0, 0, 2);
    tbl[16] = mk(1, 0, 32'hFFC,      32'h0,        0, 0, 32'h0,    32'h0,        1, 0, 0, 0);
    tbl[17] = mk(1, 0, 32'h24,       32'h0,        0, 0, 32'h0,    32'h0,        1, 0, 0, 0);
    tbl[18] = mk(1, 1, 32'h1000,     32'h00000055, 0, 0, 32'h0,    32'h0,        1, 0, 0, 0);
    tbl[19] = mk(1, 0, 32'h0,        32'h0,        0, 0, 32'h0,    32'h0,        1, 0, 0, 0);

    // Reset with a write request pending: nothing may be granted or written.
    tb_clear = 1'b1;
    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'h77; pc0 = 32'h0;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h14; wdata1 = 32'h88; pc1 = 32'h0;
    repeat (2) @(negedge clk);
    check("reset gnt0", 32'(gnt0), 32'h0);
    check("reset gnt1", 32'(gnt1), 32'h0);
    check("reset mem_we", 32'(mem_we), 32'h0);
    check("reset rvalid", {30'h0, rvalid1, rvalid0}, 32'h0);
    check("reset rdata0", rdata0, 32'h0);
    check("reset rdata1", rdata1, 32'h0);
    check("reset err", {30'h0, err1, err0}, 32'h0);
    check("reset starve_cnt", 32'(dut.u_starve.starve_cnt), 32'h0);
    reset = 1'b0;
    tb_clear = 1'b0;
    req0 = 1'b0; req1 = 1'b0;

    for (int i = 0; i < 20; i++) apply(tbl[i], $sformatf("v%0d", i));

    // Read granted at N, reset at N+1 with a write requested; N+2 must be silent.
    apply(mk(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0), "rst_n");
    @(negedge clk);
    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h30; wdata0 = 32'hCAFEF00D; pc0 = 32'h0;
    #1;
    check("rst_n1 gnt0", 32'(gnt0), 32'h0);
    check("rst_n1 mem_we", 32'(mem_we), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    req0 = 1'b0; we0 = 1'b0;
    #1;
    check("rst_n2 rvalid0", 32'(rvalid0), 32'h0);
    check("rst_n2 rdata0", rdata0, 32'h0);
    apply(mk(1, 0, 32'h30, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0), "post_rst 0x30");
    apply(mk(0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0, 0, 1, 0, 0), "post_rst 0x10");

    apply(mk(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0), "drain");
    repeat (3) @(negedge clk);
    check("scoreboard drained", 32'(sbq.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
